uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a valid/ready output handshake,
// and one-cycle frame-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned DIV = CLK_FREQ / (16 * BAUD_RATE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TickMax = CW'(DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e        state_q, state_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_sync_q, rx_sync_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    samp_cnt_q, samp_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_error_q, frame_error_d;
    logic          overrun_q, overrun_d;
    logic          tick;
    logic          deliver;

    always_comb begin
        rx_meta_d     = rx;
        rx_sync_d     = rx_meta_q;
        state_d       = state_q;
        samp_cnt_d    = samp_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        deliver       = 1'b0;
        tick          = (tick_cnt_q == TickMax);
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                    samp_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (samp_cnt_q == 4'd7) begin
                        samp_cnt_d = '0;
                        state_d    = rx_sync_q ? StIdle : StData;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    // 4-bit sample counter wraps to 0 on the 16th tick.
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == 4'd15) begin
                        shift_d   = {rx_sync_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StStop;
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == 4'd15) begin
                        if (rx_sync_q) begin
                            deliver = 1'b1;
                            state_d = StIdle;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = StWaitHigh;
                        end
                    end
                end
            end
            StWaitHigh: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // An accept in the delivery cycle frees the slot for the new byte.
        if (deliver) begin
            if (!data_valid_q || data_ready) begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q       <= StIdle;
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            tick_cnt_q    <= '0;
            samp_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            tick_cnt_q    <= tick_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule
